dmux_stream: RTL and testbench

- Parametrised, registered successor to the 1-bit 8-way demultiplexer.
- Routes a WIDTH-bit valid/ready input stream to one of CHANNELS output streams, selected per beat, or broadcasts to all channels.
- Each output has a one-entry pipeline register, giving a fixed 1-cycle latency and full throughput under no backpressure.
- Sits between a single producer and N independent consumers in the datapath.

---
 rtl/dmux_stream.sv | 123 ++++++++++++
 tb/tb_dmux_stream.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux_stream.sv
// dmux_stream: routes one WIDTH-bit valid/ready input stream to one of
// CHANNELS output streams, or broadcasts a beat to all of them.
// Each channel has a one-entry output register. A unicast beat therefore
// reaches its channel one cycle after it is accepted, and a channel can take
// one beat every cycle while its consumer keeps out_ready high.
// in_ready is the only combinational output.
module dmux_stream #(
   parameter  int WIDTH    = 1,
   parameter  int CHANNELS = 8,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH-1:0]          in_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [SEL_W-1:0]          sel_i,
   input  logic                      bcast_i,
   output logic [CHANNELS*WIDTH-1:0] out_o,
   output logic [CHANNELS-1:0]       out_valid_o,
   input  logic [CHANNELS-1:0]       out_ready_i,
   output logic                      err_sel_o
);

   // The select is widened by one bit so that the CHANNELS limit itself
   // fits. This keeps the range check exact for every legal CHANNELS,
   // including powers of two.
   localparam int               SW1    = SEL_W + 1;
   localparam logic [SEL_W:0]   CH_LIM = SW1'(CHANNELS);

   logic [CHANNELS*WIDTH-1:0] out_q;
   logic [CHANNELS*WIDTH-1:0] out_d;
   logic [CHANNELS-1:0]       out_valid_q;
   logic [CHANNELS-1:0]       out_valid_d;
   logic                      err_sel_q;
   logic                      err_sel_d;

   logic [CHANNELS-1:0]       free_s;
   logic [CHANNELS-1:0]       target_s;
   logic [CHANNELS-1:0]       load_s;
   logic [SEL_W:0]            sel_ext_s;
   logic                      sel_in_range_s;
   logic                      ready_s;
   logic                      accept_s;

   // Find the slots that can take a beat this cycle and the channels this
   // beat is aimed at.
   always_comb begin
      free_s         = ~out_valid_q | out_ready_i;
      sel_ext_s      = {1'b0, sel_i};
      sel_in_range_s = (sel_ext_s < CH_LIM);
      target_s       = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (bcast_i) begin
            target_s[i] = 1'b1;
         end else if (sel_in_range_s && (sel_ext_s == SW1'(i))) begin
            target_s[i] = 1'b1;
         end else begin
            target_s[i] = 1'b0;
         end
      end
   end

   // A broadcast needs every slot free, so it is never split across
   // channels. A unicast needs only its own slot. An out-of-range select is
   // always taken so that it can be dropped.
   always_comb begin
      ready_s = 1'b1;
      if (bcast_i) begin
         ready_s = &free_s;
      end else if (sel_in_range_s) begin
         ready_s = |(target_s & free_s);
      end else begin
         ready_s = 1'b1;
      end
   end

   // Next state per channel. A load takes priority over a drain, so a slot
   // that is emptied and refilled in the same cycle leaves no bubble.
   // Drained data is kept; only the valid bit clears.
   always_comb begin
      accept_s    = in_valid_i & ready_s;
      load_s      = '0;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (accept_s) begin
         load_s = target_s;
      end else begin
         load_s = '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
         if (load_s[i]) begin
            out_valid_d[i]             = 1'b1;
            out_d[i*WIDTH +: WIDTH]    = in_i;
         end else if (out_ready_i[i]) begin
            out_valid_d[i]             = 1'b0;
         end else begin
            out_valid_d[i]             = out_valid_q[i];
         end
      end
      err_sel_d = accept_s & ~bcast_i & ~sel_in_range_s;
   end

   // Output registers. Reset clears them at once, without waiting for a
   // clock edge, and any buffered beats are lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= '0;
         err_sel_q   <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         err_sel_q   <= err_sel_d;
      end
   end

   assign in_ready_o  = ready_s;
   assign out_o       = out_q;
   assign out_valid_o = out_valid_q;
   assign err_sel_o   = err_sel_q;

endmodule

// File: tb/tb_dmux_stream.sv
// Bench for dmux_stream. Two instances are used: an 8-channel one with a
// power-of-two channel count, and a 6-channel one where an out-of-range
// select can occur. A per-channel reference model, built from the
// valid/ready rules, is compared with both instances on every falling edge.
// Directed scenarios with hand-computed values come first, then a
// randomized phase that keeps to the producer hold rule.
module tb_dmux_stream;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 8-channel instance (a_*)
   logic [7:0]  a_in;
   logic        a_vin;
   logic        a_rdy;
   logic [2:0]  a_sel;
   logic        a_bc;
   logic [63:0] a_out;
   logic [7:0]  a_val;
   logic [7:0]  a_ordy;
   logic        a_err;
   // 6-channel instance (b_*)
   logic [7:0]  b_in;
   logic        b_vin;
   logic        b_rdy;
   logic [2:0]  b_sel;
   logic        b_bc;
   logic [47:0] b_out;
   logic [5:0]  b_val;
   logic [5:0]  b_ordy;
   logic        b_err;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state: per-instance, per-channel valid bit and data
   logic       mv [2][8];
   logic [7:0] md [2][8];
   logic       me [2];
   logic       a_acc;
   logic       b_acc;

   dmux_stream #(.WIDTH(8), .CHANNELS(8)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_i(a_in), .in_valid_i(a_vin), .in_ready_o(a_rdy),
      .sel_i(a_sel), .bcast_i(a_bc),
      .out_o(a_out), .out_valid_o(a_val), .out_ready_i(a_ordy),
      .err_sel_o(a_err)
   );

   dmux_stream #(.WIDTH(8), .CHANNELS(6)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_i(b_in), .in_valid_i(b_vin), .in_ready_o(b_rdy),
      .sel_i(b_sel), .bcast_i(b_bc),
      .out_o(b_out), .out_valid_o(b_val), .out_ready_i(b_ordy),
      .err_sel_o(b_err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Compare one instance against the model, then step the model across the
   // next rising edge using the inputs that are stable at this falling edge.
   task automatic cmp(input int k, input int nch, input logic [7:0] din, input logic vin,
                      input logic [2:0] s, input logic bc, input logic [7:0] ordy,
                      input logic [63:0] dout, input logic [7:0] dval, input logic derr,
                      input logic drdy);
      logic [7:0]  ev;
      logic [63:0] ed;
      logic        er;
      logic        allf;
      logic        acc;
      int          si;
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            mv[k][i] = 1'b0;
            md[k][i] = 8'h00;
         end
         me[k] = 1'b0;
      end
      ev = 8'h00;
      ed = 64'h0;
      for (int i = 0; i < nch; i++) begin
         ev[i]        = mv[k][i];
         ed[i*8 +: 8] = md[k][i];
      end
      si   = int'(s);
      allf = 1'b1;
      for (int i = 0; i < nch; i++) begin
         if (mv[k][i] && !ordy[i]) allf = 1'b0;
      end
      if (bc)            er = allf;
      else if (si < nch) er = !mv[k][si] || ordy[si];
      else               er = 1'b1;
      chk($sformatf("d%0d out_valid", k), 64'(dval), 64'(ev));
      chk($sformatf("d%0d out", k), dout, ed);
      chk($sformatf("d%0d err_sel", k), 64'(derr), 64'(me[k]));
      chk($sformatf("d%0d in_ready", k), 64'(drdy), 64'(er));
      if (rst_n) begin
         acc = vin && er;
         for (int i = 0; i < nch; i++) begin
            if (acc && (bc || si == i)) begin
               mv[k][i] = 1'b1;
               md[k][i] = din;
            end else if (ordy[i]) begin
               mv[k][i] = 1'b0;
            end
         end
         me[k] = acc && !bc && (si >= nch);
      end
   endtask

   // Advance one cycle. Checking is done on the falling edge, and control
   // returns just after the next rising edge.
   task automatic tick();
      @(negedge clk);
      a_acc = a_vin & a_rdy;
      b_acc = b_vin & b_rdy;
      cmp(0, 8, a_in, a_vin, a_sel, a_bc, a_ordy, a_out, a_val, a_err, a_rdy);
      cmp(1, 6, b_in, b_vin, b_sel, b_bc, {2'b11, b_ordy}, {16'h0, b_out},
          {2'b00, b_val}, b_err, b_rdy);
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         me[k] = 1'b0;
         for (int i = 0; i < 8; i++) begin
            mv[k][i] = 1'b0;
            md[k][i] = 8'h00;
         end
      end
      a_in = 8'h00; a_vin = 1'b0; a_sel = 3'd0; a_bc = 1'b0; a_ordy = 8'hFF;
      b_in = 8'h00; b_vin = 1'b0; b_sel = 3'd0; b_bc = 1'b0; b_ordy = 6'h3F;
      a_acc = 1'b0; b_acc = 1'b0;

      // reset
      tick();
      tick();
      chk("rst out_valid", 64'(a_val), 64'h0);
      chk("rst out", a_out, 64'h0);
      chk("rst in_ready", 64'(a_rdy), 64'h1);
      chk("rst err_sel", 64'(b_err), 64'h0);
      rst_n = 1'b1;

      // unicast
      a_in = 8'hA5; a_sel = 3'd3; a_vin = 1'b1;
      tick();
      chk("uni out_valid", 64'(a_val), 64'h08);
      chk("uni out3", 64'(a_out[31:24]), 64'hA5);
      a_vin = 1'b0;
      tick();
      chk("uni drained", 64'(a_val), 64'h00);

      // backpressure and independence
      a_ordy = 8'hFB; a_sel = 3'd2; a_in = 8'h11; a_vin = 1'b1;
      #1 chk("bp first ready", 64'(a_rdy), 64'h1);
      tick();
      chk("bp ch2 data", 64'(a_out[23:16]), 64'h11);
      a_in = 8'h22;
      #1 chk("bp blocked", 64'(a_rdy), 64'h0);
      tick();
      tick();
      chk("bp still blocked", 64'(a_rdy), 64'h0);
      chk("bp ch2 hold", 64'(a_out[23:16]), 64'h11);
      a_sel = 3'd5; a_in = 8'h55;
      #1 chk("bp other ready", 64'(a_rdy), 64'h1);
      tick();
      chk("bp valid 2+5", 64'(a_val), 64'h24);
      chk("bp ch5 data", 64'(a_out[47:40]), 64'h55);
      chk("bp ch2 stable", 64'(a_out[23:16]), 64'h11);
      a_sel = 3'd2; a_in = 8'h22; a_ordy = 8'hFF;
      #1 chk("bp released", 64'(a_rdy), 64'h1);
      tick();
      chk("bp reload", 64'(a_val), 64'h04);
      chk("bp ch2 new", 64'(a_out[23:16]), 64'h22);
      a_vin = 1'b0;
      tick();

      // streaming through one slot
      a_sel = 3'd1; a_vin = 1'b1;
      for (int v = 1; v <= 4; v++) begin
         a_in = 8'(v);
         #1 chk("stream ready", 64'(a_rdy), 64'h1);
         tick();
         chk("stream valid", 64'(a_val), 64'h02);
         chk("stream data", 64'(a_out[15:8]), 64'(v));
      end
      a_vin = 1'b0;
      tick();

      // broadcast blocked by a stalled channel
      a_ordy = 8'hBF; a_sel = 3'd6; a_in = 8'h66; a_vin = 1'b1;
      tick();
      chk("bc stall setup", 64'(a_val), 64'h40);
      a_bc = 1'b1; a_in = 8'h3C;
      for (int n = 0; n < 3; n++) begin
         #1 chk("bc blocked", 64'(a_rdy), 64'h0);
         tick();
      end
      a_ordy = 8'hFF;
      #1 chk("bc ready", 64'(a_rdy), 64'h1);
      tick();
      chk("bc all valid", 64'(a_val), 64'hFF);
      chk("bc all data", a_out, 64'h3C3C3C3C3C3C3C3C);
      a_bc = 1'b0; a_vin = 1'b0;
      tick();

      // out-of-range select on the 6-channel instance
      b_ordy = 6'h3E; b_sel = 3'd0; b_in = 8'h77; b_vin = 1'b1;
      tick();
      b_sel = 3'd7; b_in = 8'h99;
      #1 chk("oor ready", 64'(b_rdy), 64'h1);
      tick();
      chk("oor err", 64'(b_err), 64'h1);
      chk("oor valid kept", 64'(b_val), 64'h01);
      chk("oor ch0 kept", 64'(b_out[7:0]), 64'h77);
      b_vin = 1'b0;
      tick();
      chk("oor err pulse", 64'(b_err), 64'h0);
      b_ordy = 6'h3F;
      tick();

      // asynchronous reset with four stalled beats
      a_ordy = 8'h00; a_vin = 1'b1;
      for (int s = 0; s < 4; s++) begin
         a_sel = 3'(s); a_in = 8'(8'h10 + s);
         tick();
      end
      a_vin = 1'b0;
      chk("ar stalled", 64'(a_val), 64'h0F);
      #2 rst_n = 1'b0;
      #1;
      chk("ar valid cleared", 64'(a_val), 64'h00);
      chk("ar out cleared", a_out, 64'h0);
      tick();
      tick();
      rst_n = 1'b1;
      a_ordy = 8'hFF; a_in = 8'hA5; a_sel = 3'd3; a_vin = 1'b1;
      tick();
      chk("ar unicast valid", 64'(a_val), 64'h08);
      chk("ar unicast data", 64'(a_out[31:24]), 64'hA5);
      a_vin = 1'b0;
      tick();

      // randomized traffic on both instances
      for (int c = 0; c < 3000; c++) begin
         if (!(a_vin && !a_acc)) begin
            a_vin = ($urandom_range(0, 3) != 0);
            a_in  = 8'($urandom);
            a_sel = 3'($urandom);
            a_bc  = ($urandom_range(0, 7) == 0);
         end
         if (!(b_vin && !b_acc)) begin
            b_vin = ($urandom_range(0, 3) != 0);
            b_in  = 8'($urandom);
            b_sel = 3'($urandom);
            b_bc  = ($urandom_range(0, 7) == 0);
         end
         for (int j = 0; j < 8; j++) a_ordy[j] = ($urandom_range(0, 9) < 7);
         for (int j = 0; j < 6; j++) b_ordy[j] = ($urandom_range(0, 9) < 7);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
